// File: rtl/sample_pkg.sv
// Shared types and default sizes for the accelerometer sample path.
package sample_pkg;

    localparam int unsigned SAMPLE_WIDTH    = 16;
    localparam int unsigned FIFO_ADDR_WIDTH = 4;

    typedef logic [SAMPLE_WIDTH-1:0]  sample_t;
    typedef logic [FIFO_ADDR_WIDTH:0] fifo_count_t;

endpackage

// File: rtl/sample_fifo_if.sv
// Push/pop handshake between the capture front-end, the FIFO and the drain path.
interface sample_fifo_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output wr_en,
        output wr_data,
        output rd_en,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  rd_en,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/fifo_ram_dp.sv
// Simple dual-port RAM: synchronous write, enabled registered read, read-first.
module fifo_ram_dp #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read sees the pre-write word on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO: pointers, occupancy, flags and sticky errors around fifo_ram_dp.
module sample_fifo
    import sample_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = SAMPLE_WIDTH,
    parameter int unsigned ADDR_WIDTH    = FIFO_ADDR_WIDTH,
    parameter int unsigned AFULL_DEFAULT = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    sample_fifo_if.slave        bus,
    input  logic [ADDR_WIDTH:0] afull_thresh,
    output logic [ADDR_WIDTH:0] count,
    output logic                empty,
    output logic                full,
    output logic                almost_full,
    output logic                overflow,
    output logic                underflow,
    input  logic                clr_err
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    if (AFULL_DEFAULT > DEPTH) begin : g_bad_afull
        $error("AFULL_DEFAULT exceeds FIFO depth");
    end

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                rd_valid_q;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                push_ok, pop_ok;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_CNT);
    assign almost_full = (count_q >= afull_thresh);

    // Acceptance uses pre-edge flags, so a same-cycle pop never makes room for a push.
    assign push_ok = bus.wr_en & ~full & ~flush;
    assign pop_ok  = bus.rd_en & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok) count_d = count_q + 1'b1;
            if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        end
    end

    // Set beats clear when both land in the same cycle.
    always_comb begin
        overflow_d  = overflow_q & ~clr_err;
        underflow_d = underflow_q & ~clr_err;
        if (bus.wr_en && full && !flush)  overflow_d  = 1'b1;
        if (bus.rd_en && empty && !flush) underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= pop_ok;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push_ok & ~rst),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata (bus.wr_data),
        .re    (pop_ok),
        .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (bus.rd_data)
    );

    assign bus.rd_valid = rd_valid_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
endmodule

// File: tb/tb_sample_fifo.sv
// Directed self-checking bench for sample_fifo with DEPTH = 16.
module tb_sample_fifo;
    import sample_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        clr_err;
    logic [4:0]  afull_thresh;
    logic [4:0]  count;
    logic        empty, full, almost_full, overflow, underflow;

    int checks = 0;
    int passes = 0;

    sample_fifo_if #(.DATA_WIDTH(16)) bus ();

    sample_fifo #(
        .DATA_WIDTH    (16),
        .ADDR_WIDTH    (4),
        .AFULL_DEFAULT (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus.slave),
        .afull_thresh (afull_thresh),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        assert (got === exp) begin
            passes = passes + 1;
        end else begin
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; clr_err = 1'b0; afull_thresh = 5'd12;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_afull", 32'(almost_full), 0);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_underflow", 32'(underflow), 0);
        afull_thresh = 5'd0;
        #1 check("afull_thresh0", 32'(almost_full), 1);
        afull_thresh = 5'd12;

        // Pop while empty
        bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
        check("uf_set", 32'(underflow), 1);
        check("uf_count", 32'(count), 0);
        check("uf_no_valid", 32'(bus.rd_valid), 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("uf_clr", 32'(underflow), 0);

        // Fill 16 words
        bus.wr_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus.wr_data = 16'(i);
            tick();
            check("fill_count", 32'(count), 32'(i));
            check("fill_afull", 32'(almost_full), (i >= 12) ? 1 : 0);
        end
        check("fill_full", 32'(full), 1);
        bus.wr_data = 16'h00ff; tick(); bus.wr_en = 1'b0;
        check("of_set", 32'(overflow), 1);
        check("of_count", 32'(count), 16);

        // Drain in order
        bus.rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("drain_valid", 32'(bus.rd_valid), 1);
            check("drain_data", 32'(bus.rd_data), 32'(i));
        end
        bus.rd_en = 1'b0; tick();
        check("drain_valid_end", 32'(bus.rd_valid), 0);
        check("drain_empty", 32'(empty), 1);
        check("drain_hold", 32'(bus.rd_data), 32'h10);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("of_clr", 32'(overflow), 0);

        // Wrap-around: 10 in, 10 out, then streaming
        bus.wr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.wr_data = 16'(16'h0100 + i); tick();
        end
        bus.wr_en = 1'b0;
        check("wrap10_count", 32'(count), 10);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("wrap10_data", 32'(bus.rd_data), 32'(16'h0100 + i));
        end
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b1; bus.wr_data = 16'h0200; tick();
        bus.rd_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            bus.wr_data = 16'(16'h0200 + k);
            tick();
            check("stream_data", 32'(bus.rd_data), 32'(16'h0200 + k - 1));
            check("stream_count", 32'(count), 1);
        end
        bus.wr_en = 1'b0; tick(); bus.rd_en = 1'b0;
        check("stream_last", 32'(bus.rd_data), 32'h0228);
        check("stream_empty", 32'(empty), 1);

        // Push+pop at full: pop wins, push rejected
        bus.wr_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus.wr_data = 16'(16'h0300 + i); tick();
        end
        check("full2", 32'(full), 1);
        bus.wr_data = 16'h0bad; bus.rd_en = 1'b1; tick();
        bus.wr_en = 1'b0;
        check("fullpp_count", 32'(count), 15);
        check("fullpp_data", 32'(bus.rd_data), 32'h0301);
        check("fullpp_of", 32'(overflow), 1);
        for (int i = 2; i <= 16; i++) begin
            tick();
            check("fullpp_drain", 32'(bus.rd_data), 32'(16'h0300 + i));
        end
        bus.rd_en = 1'b0; tick();
        check("fullpp_empty", 32'(empty), 1);

        // Push+pop at empty: push only
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 16'h0aaa; tick();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        check("emptypp_count", 32'(count), 1);
        check("emptypp_valid", 32'(bus.rd_valid), 0);
        check("emptypp_uf", 32'(underflow), 1);
        bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
        check("emptypp_data", 32'(bus.rd_data), 32'h0aaa);
        clr_err = 1'b1; tick(); clr_err = 1'b0;

        // Flush with 7 held and overflow set
        bus.wr_en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            bus.wr_data = 16'(16'h0400 + i); tick();
        end
        bus.wr_en = 1'b0;
        check("fl_of", 32'(overflow), 1);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        bus.rd_en = 1'b0;
        check("fl_count7", 32'(count), 7);
        flush = 1'b1; tick(); flush = 1'b0;
        check("fl_count", 32'(count), 0);
        check("fl_empty", 32'(empty), 1);
        check("fl_of_kept", 32'(overflow), 1);
        check("fl_data_kept", 32'(bus.rd_data), 32'h0409);
        clr_err = 1'b1; bus.rd_en = 1'b1; tick(); clr_err = 1'b0; bus.rd_en = 1'b0;
        check("clr_uf_wins", 32'(underflow), 1);
        check("clr_of", 32'(overflow), 0);
        bus.wr_en = 1'b1; bus.wr_data = 16'h0555; tick(); bus.wr_en = 1'b0;
        bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
        check("post_flush_data", 32'(bus.rd_data), 32'h0555);

        // Reset during a pop with 5 held
        bus.wr_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.wr_data = 16'(16'h0600 + i); tick();
        end
        bus.wr_en = 1'b0;
        check("mid_count5", 32'(count), 5);
        bus.rd_en = 1'b1; rst = 1'b1; tick(); rst = 1'b0; bus.rd_en = 1'b0;
        check("mid_valid", 32'(bus.rd_valid), 0);
        check("mid_data", 32'(bus.rd_data), 0);
        check("mid_count", 32'(count), 0);
        check("mid_uf", 32'(underflow), 0);
        tick();
        check("mid_no_stale", 32'(bus.rd_valid), 0);
        check("mid_empty", 32'(empty), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
